line_echo_ctrl: RTL and testbench
=================================

LINE_ECHO_CTRL -- requirements
Module: line_echo_ctrl

Interface
REQ-001 SHALL have parameter LINE_MAX, default 64, meaning line buffer depth in bytes (power of 2, 4..256).
REQ-002 SHALL have parameter EOL, default 8'h0D, meaning the byte that terminates a received line.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port n_rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port rx_data, input, 8, head byte of the receive FIFO.
REQ-006 SHALL have port rx_valid, input, 1, receive FIFO non-empty.
REQ-007 SHALL have port rx_pop, output, 1, one-cycle pop pulse to the receive FIFO.
REQ-008 SHALL have port tx_data, output, 8, byte presented to the transmit FIFO.
REQ-009 SHALL have port tx_push, output, 1, one-cycle push pulse to the transmit FIFO.
REQ-010 SHALL have port tx_full, input, 1, transmit FIFO full.
REQ-011 SHALL have port busy, output, 1, high whenever state is not COLLECT.
REQ-012 SHALL have port ovf, output, 1, one-cycle pulse when a line is cut at LINE_MAX.
REQ-013 SHALL have port line_count, output, 8, number of lines echoed, wrapping 255->0.

Function
REQ-014 SHALL implement states COLLECT, ECHO, SEND_CR, SEND_LF; the reset state is COLLECT.
REQ-015 In COLLECT, the block SHALL assert rx_pop for one cycle when rx_valid=1 and rx_pop was 0 in the previous cycle, so pops occur at most every second cycle.
REQ-016 In the rx_pop cycle, the block SHALL capture rx_data.
REQ-017 When the captured byte equals EOL, the block SHALL go to ECHO with the read index at 0, and SHALL NOT store the byte.
REQ-018 When the captured byte is 8'h08 and count>0, the block SHALL decrement count; when count=0, the block SHALL ignore the byte.
REQ-019 For any other byte, the block SHALL write it to buf[count] and increment count.
REQ-020 If the increment makes count equal LINE_MAX, the block SHALL pulse ovf in the next cycle and go to ECHO.
REQ-021 In ECHO, SEND_CR and SEND_LF, the block SHALL keep rx_pop=0; incoming bytes remain in the receive FIFO.
REQ-022 In ECHO, while index<count and tx_full=0 and tx_push was 0 in the previous cycle, the block SHALL drive tx_data=buf[index], pulse tx_push and increment index.
REQ-023 When index=count (including count=0), ECHO SHALL go to SEND_CR.
REQ-024 SEND_CR SHALL push 8'h0D under the rule in REQ-022, then go to SEND_LF.
REQ-025 SEND_LF SHALL push 8'h0A under the rule in REQ-022, clear count, increment line_count and return to COLLECT.
REQ-026 While tx_full=1, the block SHALL hold tx_push=0 and keep tx_data and index unchanged, with no byte lost or duplicated.
REQ-027 tx_data SHALL be valid in the tx_push cycle; tx_data is don't-care when tx_push=0.
REQ-028 Buffer read latency SHALL be absorbed internally; tx_push SHALL NOT be asserted before buf[index] is valid on tx_data.

Reset
REQ-029 On n_rst=0, regardless of the current state, the block SHALL asynchronously set state=COLLECT, count=0, index=0, line_count=0, rx_pop=0, tx_push=0, ovf=0 and tx_data=8'h00.
REQ-030 Buffer contents SHALL NOT be reset.
REQ-031 After n_rst deasserts, the first rx_pop SHALL occur no earlier than the second rising clk edge.

Structure
REQ-032 Package line_echo_pkg SHALL hold the state enum and the constants ASCII_CR=8'h0D, ASCII_LF=8'h0A and ASCII_BS=8'h08.
REQ-033 The block SHALL contain one sub-module, line_buf: a LINE_MAX x 8 single-write, single-read RAM with a registered read and no reset.
REQ-034 count and index SHALL be $clog2(LINE_MAX)+1 bits wide so that LINE_MAX itself is representable.

Verification
REQ-035 The bench SHALL feed "ab"+0D and check that tx receives 61 62 0D 0A, that line_count=1 and that busy falls after the LF push.
REQ-036 The bench SHALL feed "abc"+08+"d"+0D and check that tx receives 61 62 64 0D 0A.
REQ-037 The bench SHALL feed 08 0D and check that tx receives 0D 0A only.
REQ-038 With LINE_MAX=4, the bench SHALL feed "abcdef"+0D and check that ovf pulses once and that tx receives 61 62 63 64 0D 0A, then 65 66 0D 0A.
REQ-039 The bench SHALL hold tx_full=1 for 20 cycles in the middle of an echo and check that tx_push stays 0 throughout and that the resumed stream is complete and in order.
REQ-040 The bench SHALL assert n_rst=0 during SEND_CR and check that all outputs are 0 immediately and that the next line "x"+0D echoes 78 0D 0A with line_count=1.

Source files
------------

// File: rtl/line_echo_pkg.sv
// Shared types and character constants for the line echo controller.
package line_echo_pkg;

  // Controller phases: gather a line, echo it back, then terminate with CR LF.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ECHO    = 2'd1,
    SEND_CR = 2'd2,
    SEND_LF = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_BS = 8'h08;

endpackage

// File: rtl/line_buf.sv
// Line storage: DEPTH x 8 RAM, one write port, one read port with a
// registered read. Contents are deliberately not reset so it maps to block RAM.
module line_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Synchronous write and registered read; read data appears one edge after rd_addr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_echo_ctrl.sv
// Line echo controller: pops bytes from a receive FIFO into a line buffer
// (with backspace editing), and on EOL or a full buffer echoes the line to a
// transmit FIFO followed by CR LF.
module line_echo_ctrl
  import line_echo_pkg::*;
#(
  parameter int         LINE_MAX = 64,
  parameter logic [7:0] EOL      = 8'h0D
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_pop,
  output logic [7:0] tx_data,
  output logic       tx_push,
  input  logic       tx_full,
  output logic       busy,
  output logic       ovf,
  output logic [7:0] line_count
);

  localparam int AW = $clog2(LINE_MAX);
  // One extra bit so a completely full line (count == LINE_MAX) is representable.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(LINE_MAX);
  localparam logic [CW-1:0] ONE        = CW'(1);

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] index;
  logic [CW-1:0] count_inc;
  logic          armed;     // blocks popping on the first edge after reset
  logic          rd_ok;     // rd_data currently holds buf[index]
  logic          tx_slot;   // transmit side can accept a push on this edge
  logic          wr_en;
  logic [7:0]    rd_data;

  assign count_inc = count + ONE;
  assign tx_slot   = !tx_full && !tx_push;
  assign busy      = (state != COLLECT);
  assign wr_en     = (state == COLLECT) && rx_pop &&
                     (rx_data != EOL) && (rx_data != ASCII_BS);

  line_buf #(
    .DEPTH (LINE_MAX),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (index[AW-1:0]),
    .rd_data (rd_data)
  );

  // Main controller: state, counters and all registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= COLLECT;
      count      <= '0;
      index      <= '0;
      line_count <= '0;
      rx_pop     <= 1'b0;
      tx_push    <= 1'b0;
      ovf        <= 1'b0;
      tx_data    <= 8'h00;
      armed      <= 1'b0;
      rd_ok      <= 1'b0;
    end else begin
      armed   <= 1'b1;
      rx_pop  <= 1'b0;
      tx_push <= 1'b0;
      ovf     <= 1'b0;
      rd_ok   <= 1'b0;
      case (state)
        COLLECT: begin
          if (rx_pop) begin
            // The FIFO drops its head on this edge, so rx_data is the popped byte.
            if (rx_data == EOL) begin
              state <= ECHO;
              index <= '0;
            end else if (rx_data == ASCII_BS) begin
              if (count != '0) begin
                count <= count - ONE;
              end
            end else begin
              count <= count_inc;
              if (count_inc == FULL_COUNT) begin
                ovf   <= 1'b1;
                state <= ECHO;
                index <= '0;
              end
            end
          end else if (rx_valid && armed) begin
            rx_pop <= 1'b1;
          end
        end
        ECHO: begin
          if (index == count) begin
            state <= SEND_CR;
          end else if (tx_slot && rd_ok) begin
            tx_data <= rd_data;
            tx_push <= 1'b1;
            index   <= index + ONE;
          end else begin
            // index held still for a full edge, so the RAM output now matches it.
            rd_ok <= 1'b1;
          end
        end
        SEND_CR: begin
          if (tx_slot) begin
            tx_data <= ASCII_CR;
            tx_push <= 1'b1;
            state   <= SEND_LF;
          end
        end
        SEND_LF: begin
          if (tx_slot) begin
            tx_data    <= ASCII_LF;
            tx_push    <= 1'b1;
            count      <= '0;
            index      <= '0;
            line_count <= line_count + 8'd1;
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_line_echo_ctrl.sv
// Self-checking bench for line_echo_ctrl: a queue-based receive FIFO, a
// line-level reference model producing the expected transmit byte stream,
// and a per-cycle monitor comparing every push against that stream.
module tb_line_echo_ctrl;
  import line_echo_pkg::*;

  localparam int LM = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       tx_full;
  logic       busy;
  logic       ovf;
  logic [7:0] line_count;

  int total = 0;
  int bad   = 0;

  byte unsigned rxq[$];     // receive FIFO contents
  int           expq[$];    // expected tx bytes; values above 255 mark a line-ending LF
  byte unsigned txlog[$];   // every byte the DUT pushed
  byte unsigned mline[$];   // model's current partial line
  int exp_lines = 0;
  int exp_ovf   = 0;
  int seen_ovf  = 0;
  int lc_exp    = 0;
  int txbase, sbase, mbase;

  int  full_mode = 0;       // 0: never full, 1: random, 2: held full
  logic full_rnd = 1'b0;
  bit  pop_seen = 0;
  bit  full_at_edge = 0;
  bit  prev_pop = 0, prev_push = 0, prev_ovf = 0;

  assign tx_full = (full_mode == 2) || full_rnd;

  line_echo_ctrl #(
    .LINE_MAX (LM),
    .EOL      (8'h0D)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_pop     (rx_pop),
    .tx_data    (tx_data),
    .tx_push    (tx_push),
    .tx_full    (tx_full),
    .busy       (busy),
    .ovf        (ovf),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Reference model: a line is emitted on EOL or as soon as it reaches LM bytes.
  task automatic emit_line();
    foreach (mline[i]) expq.push_back(int'(mline[i]));
    expq.push_back(32'h0D);
    expq.push_back(32'h10A);
    mline.delete();
    exp_lines++;
  endtask

  task automatic model_byte(input byte unsigned b);
    if (b == 8'h0D) begin
      emit_line();
    end else if (b == 8'h08) begin
      if (mline.size() > 0) void'(mline.pop_back());
    end else begin
      mline.push_back(b);
      if (mline.size() == LM) begin
        exp_ovf++;
        emit_line();
      end
    end
  endtask

  task automatic send_byte(input byte unsigned b);
    rxq.push_back(b);
    model_byte(b);
  endtask

  task automatic send_str(input string s);
    byte unsigned b;
    txbase = txlog.size();
    sbase  = seen_ovf;
    mbase  = exp_ovf;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_byte(b);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (rxq.size() == 0 && expq.size() == 0 && !busy && !rx_pop) done = 1;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Pins the model against the literal, then lets the DUT run and checks the echo.
  task automatic check_phase(input string tag, input string lit, input int lit_ovf, input bit hold);
    byte unsigned b;
    int n;
    bit seen;
    chk({tag, "_model_len"}, expq.size(), lit.len());
    n = (expq.size() < lit.len()) ? expq.size() : lit.len();
    for (int i = 0; i < n; i++) begin
      b = lit[i];
      chk({tag, "_model_byte"}, expq[i] & 255, int'(b));
    end
    chk({tag, "_model_ovf"}, exp_ovf - mbase, lit_ovf);
    if (hold) begin
      seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
        @(negedge clk);
        if (txlog.size() > txbase) seen = 1;
      end
      if (!seen) chk({tag, "_first_push_timeout"}, 0, 1);
      #1 full_mode = 2;
      @(negedge clk);
      repeat (20) begin
        @(negedge clk);
        chk({tag, "_push_while_held"}, int'(tx_push), 0);
      end
      #1 full_mode = 0;
    end
    wait_idle(tag);
    chk({tag, "_echo_len"}, txlog.size() - txbase, lit.len());
    n = ((txlog.size() - txbase) < lit.len()) ? (txlog.size() - txbase) : lit.len();
    for (int i = 0; i < n; i++) begin
      b = lit[i];
      chk({tag, "_echo_byte"}, int'(txlog[txbase + i]), int'(b));
    end
    chk({tag, "_line_count"}, int'(line_count), exp_lines % 256);
    chk({tag, "_ovf_pulses"}, seen_ovf - sbase, exp_ovf - mbase);
    $display("phase %s: %0d bytes echoed, line_count=%0d", tag, txlog.size() - txbase, line_count);
  endtask

  // Receive FIFO and random back-pressure, updated just after each rising edge.
  always @(posedge clk) begin
    full_at_edge = tx_full;
    #1;
    if (pop_seen && rxq.size() > 0) void'(rxq.pop_front());
    pop_seen = 0;
    rx_valid = (rxq.size() > 0);
    rx_data  = rx_valid ? rxq[0] : 8'h00;
    full_rnd = (full_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  // Per-cycle monitor: every push against the model stream, plus handshake rules.
  always @(negedge clk) begin
    int e;
    pop_seen = rx_pop;
    if (n_rst) begin
      if (tx_push) begin
        txlog.push_back(tx_data);
        chk("tx_back_to_back", int'(prev_push), 0);
        chk("tx_push_while_full", int'(full_at_edge), 0);
        if (expq.size() == 0) begin
          chk("tx_unexpected", int'(tx_data), -1);
        end else begin
          e = expq.pop_front();
          chk("tx_byte", int'(tx_data), e & 255);
          if (e > 255) begin
            lc_exp = (lc_exp + 1) % 256;
            chk("lc_on_lf", int'(line_count), lc_exp);
            chk("busy_on_lf", int'(busy), 0);
          end
        end
      end
      if (rx_pop) begin
        chk("rx_back_to_back", int'(prev_pop), 0);
        chk("rx_pop_busy", int'(busy), 0);
      end
      if (ovf) begin
        seen_ovf++;
        chk("ovf_single", int'(prev_ovf), 0);
      end
    end
    prev_push = n_rst && tx_push;
    prev_pop  = n_rst && rx_pop;
    prev_ovf  = n_rst && ovf;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned b;
    int elen;
    bit found;
    n_rst     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_pop", int'(rx_pop), 0);
    chk("rst_tx_push", int'(tx_push), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_line_count", int'(line_count), 0);
    chk("rst_busy", int'(busy), 0);
    #1 n_rst = 1'b1;

    send_str("ab\015");
    check_phase("ab", "ab\015\012", 0, 0);
    send_str("abc\010d\015");
    check_phase("bs_edit", "abd\015\012", 0, 0);
    send_str("\010\015");
    check_phase("bs_empty", "\015\012", 0, 0);
    send_str("abcdef\015");
    check_phase("overflow", "abcd\015\012ef\015\012", 1, 0);
    send_str("pqr\015");
    check_phase("held_full", "pqr\015\012", 0, 1);

    // Reset while the CR is pending: stall in SEND_CR, then drop n_rst mid-cycle.
    send_str("mn\015");
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (dut.state == SEND_CR) found = 1;
    end
    if (!found) chk("reach_send_cr_timeout", 0, 1);
    #1 full_mode = 2;
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_rx_pop", int'(rx_pop), 0);
    chk("mid_rst_tx_push", int'(tx_push), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_tx_data", int'(tx_data), 0);
    chk("mid_rst_line_count", int'(line_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rxq.delete();
    expq.delete();
    mline.delete();
    exp_lines = 0;
    lc_exp    = 0;
    full_mode = 0;
    repeat (2) @(negedge clk);
    send_str("x\015");
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk("no_pop_first_edge", int'(rx_pop), 0);
    check_phase("after_reset", "x\015\012", 0, 0);

    // Random lines under random back-pressure.
    full_mode = 1;
    txbase = txlog.size();
    sbase  = seen_ovf;
    mbase  = exp_ovf;
    for (int l = 0; l < 40; l++) begin
      for (int k = $urandom_range(0, 6); k > 0; k--) begin
        if ($urandom_range(0, 4) == 0) b = 8'h08;
        else begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0D || b == 8'h08) b = 8'h7A;
        end
        send_byte(b);
      end
      send_byte(8'h0D);
    end
    elen = expq.size();
    wait_idle("random");
    chk("random_echo_len", txlog.size() - txbase, elen);
    chk("random_line_count", int'(line_count), exp_lines % 256);
    chk("random_ovf_pulses", seen_ovf - sbase, exp_ovf - mbase);
    $display("phase random: %0d bytes echoed, line_count=%0d", txlog.size() - txbase, line_count);
    full_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
